// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory port: a byte-writable RAM with a
// registered read word, and an MMIO window with a debug TX FIFO, status and cycle counter.
module data_mem_responder #(
  parameter int          ADDR_W     = 10,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_RSVD   = 2'd3
  } mmio_reg_e;

  // ---------------------------------------------------------------- decode
  logic              ram_sel;
  logic              mmio_sel;
  mmio_reg_e         reg_sel;
  logic [ADDR_W-1:0] word_idx;

  assign ram_sel  = (addr[31:28] == 4'h0);
  assign mmio_sel = (addr[31:28] == MMIO_BASE[31:28]);
  assign reg_sel  = mmio_reg_e'(addr[3:2]);
  assign word_idx = addr[ADDR_W+1:2];

  // Upper RAM-region bits alias by wrap-around; byte offset is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[27:ADDR_W+2], addr[1:0]};

  // ---------------------------------------------------------------- RAM
  logic [31:0] mem [2**ADDR_W];

  // NOTE: the RAM array has no reset; resetting it would forbid mapping it
  // onto a block RAM, and software never relies on its power-up contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_sel && we[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             full;
  logic             pop;
  logic             push_req;
  logic             push;
  logic             ovf_set;
  logic             ovf_clr;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign tx_valid = (count != '0);
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  assign pop      = tx_valid && tx_ready;
  assign push_req = mmio_sel && (reg_sel == REG_TXDATA) && we[0];
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = mmio_sel && (reg_sel == REG_STATUS) && we[0] && wdata[1];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- cycle counter
  logic [31:0] cycle_cnt;
  logic        cycle_wr;

  assign cycle_wr = mmio_sel && (reg_sel == REG_CYCLE) && (we != 4'b0000);

  // The write cycle itself counts as zero, so the following cycle reads one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cycle_cnt <= '0;
    else if (cycle_wr) cycle_cnt <= 32'd1;
    else               cycle_cnt <= cycle_cnt + 32'd1;
  end

  // ---------------------------------------------------------------- read path
  logic [31:0] rd_next;

  // NOTE: rd_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_next = '0;
    if (ram_sel) begin
      rd_next = mem[word_idx];
    end else if (mmio_sel) begin
      case (reg_sel)
        REG_STATUS: rd_next = {29'b0, tx_valid, overflow, full};
        REG_CYCLE:  rd_next = cycle_cnt;
        default:    rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= rd_next;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory port.
- Accepts the core's byte-lane-aligned store data and per-byte write enables on its address.
- Returns the addressed 32-bit word one cycle later. The core performs load sign-extension using its own delayed address.
- Also decodes a small MMIO window holding a debug TX byte FIFO with a valid/ready output, a status register and a free-running cycle counter.

Parameters:
- ADDR_W, 10, word-address bits of the RAM; RAM is 2^ADDR_W 32-bit words (4 KiB default).
- FIFO_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- MMIO_BASE, 32'h1000_0000, base of the MMIO window; only bits [31:28] are decoded.

Ports:
- clk  input  1  core clock; everything is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from the core ALU; bits [1:0] are ignored.
- wdata  input  32  store data, already placed in the correct byte lanes.
- we  input  4  per-byte write enables; bit i writes wdata[8i+7:8i].
- rdata  output  32  registered read word, returned to the core as mem_out.
- tx_valid  output  1  TX FIFO head is valid.
- tx_data  output  8  TX FIFO head byte.
- tx_ready  input  1  downstream consumer accepts the head byte.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rdata=0, tx_valid=0, tx_data=0.
  - FIFO pointers and count = 0; overflow flag = 0; cycle counter = 0.
  - RAM contents are not reset.
- Decode:
  - RAM region: addr[31:28]==4'h0; word index = addr[ADDR_W+1:2]. Upper bits are ignored, so addresses alias by wrap-around.
  - MMIO region: addr[31:28]==MMIO_BASE[31:28], decoded on addr[3:2]:
    - 0 = TXDATA
    - 1 = STATUS
    - 2 = CYCLE
    - 3 = reserved
  - Any other address: writes ignored, read returns 0.
- Read:
  - Every cycle, rdata <= the word selected by the addr present in that cycle.
  - Latency is exactly 1 cycle; there is no read strobe.
  - Same-cycle read and write to the same RAM word returns the OLD word; the new data is visible from the following cycle's address.
- RAM write: on we!=0 in the RAM region, only the enabled bytes are updated at the clock edge.
- TXDATA:
  - A write with we[0]=1 pushes wdata[7:0]; other we bits are ignored.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and overflow is set (sticky).
  - Reads of TXDATA return 0.
- STATUS:
  - Read value = {29'b0, tx_valid, overflow, full}.
  - A write with we[0]=1 and wdata[1]=1 clears overflow.
  - If an overflow-setting push and a clear happen in the same cycle, set wins.
- CYCLE:
  - 32-bit counter, increments every cycle, wraps 0xFFFF_FFFF -> 0.
  - Any write with we!=0 loads 0 in that cycle; the next cycle reads 1 if sampled then.
  - A read returns the counter value at the cycle the address was presented.
- FIFO:
  - Registered output, no fall-through. A push into an empty FIFO raises tx_valid the next cycle.
  - tx_data equals the head entry whenever tx_valid=1, and holds stable while tx_valid & !tx_ready.
  - A pop occurs on tx_valid & tx_ready; the head advances next cycle.
  - Simultaneous push and pop when full: both happen, count unchanged, no overflow.
  - Simultaneous push and pop when not full: count unchanged.
  - full = (count==FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: asserting rst_n low at any point empties the FIFO immediately (tx_valid drops asynchronously) and zeroes rdata and the counter. RAM is retained.

Test Plan:
- RAM byte writes: write 0xAABBCCDD with we=4'b1111 to 0x0000_0010, then 0x0000_0011 with we=4'b0010 and wdata=0x0000_EE00. Read 0x10 -> rdata=0xAABBEEDD one cycle after the address.
- Read-during-write and aliasing: write 0x1234_5678 to word 4 while addressing it -> rdata shows the old word that cycle and 0x1234_5678 on the next read. Write at 0x0000_1010 (ADDR_W=10) -> also readable at 0x0000_0010.
- FIFO ordering with backpressure: tx_ready=0; push 0x41,0x42,0x43,0x44 -> STATUS reads 0x5. A fifth push 0x45 -> dropped, STATUS=0x7. Raise tx_ready -> tx_data sequence 0x41..0x44 on consecutive cycles, then tx_valid=0.
- Full with simultaneous push/pop: fill the FIFO, hold tx_ready=1 and push 0x55 in the same cycle -> no overflow, 0x55 emerges last. Write STATUS wdata=0x2 -> overflow clears, STATUS reads 0x0 once drained.
- CYCLE counter: read CYCLE in two reads 5 cycles apart -> difference 5. Write CYCLE -> an immediate read on the next cycle returns 1. Force the counter to 0xFFFF_FFFF via a bench override -> the next value is 0.
- Asynchronous reset with FIFO holding 3 bytes and tx_ready=0: pulse rst_n low between clock edges -> tx_valid and rdata go to 0 immediately. Previously written RAM word still reads back its value after release.
